// File: rtl/lutram_mp_pkg.sv
// Shared types and constants for the lutram_mp_array distributed-RAM storage block.
// The wr_req_t field widths track the array's WIDTH/DEPTH configuration below.
package lutram_mp_pkg;

    localparam int BANK_DEPTH = 64;
    localparam int BANK_AW    = 6;

    localparam int REQ_WIDTH  = 64;
    localparam int REQ_DEPTH  = 256;
    localparam int REQ_AW     = $clog2(REQ_DEPTH);
    localparam int REQ_BEW    = REQ_WIDTH / 8;

    typedef struct packed {
        logic [REQ_AW-1:0]    addr;
        logic [REQ_BEW-1:0]   be;
        logic [REQ_WIDTH-1:0] data;
    } wr_req_t;

    function automatic logic [REQ_WIDTH-1:0] merge_bytes(
        input logic [REQ_WIDTH-1:0] old_word,
        input logic [REQ_WIDTH-1:0] new_word,
        input logic [REQ_BEW-1:0]   be
    );
        logic [REQ_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < REQ_BEW; b++) begin
            if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lutram_mp_bank64.sv
// One 64-entry LUTRAM bank: NREAD asynchronous read ports and one byte-enabled write port.
// The storage has no reset; the top-level sweep zero-fills it.
module lutram_bank64
    import lutram_mp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREAD = 3
) (
    input  logic                       clk,
    input  logic [WIDTH/8-1:0]         wen,
    input  logic [BANK_AW-1:0]         waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [NREAD*BANK_AW-1:0]   raddr,
    output logic [NREAD*WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH/8; b++) begin
            if (wen[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREAD; i++) begin
            rdata[i*WIDTH +: WIDTH] = mem[raddr[i*BANK_AW +: BANK_AW]];
        end
    end

endmodule

// File: rtl/lutram_mp_array.sv
// Multi-read-port LUTRAM array with two arbitrated byte-enabled writers and a post-reset zero-fill sweep.
// Optional macro LUTRAM_MP_BYPASS_EN forwards same-cycle and held write data to reads.
module lutram_mp_array
    import lutram_mp_pkg::*;
#(
    parameter int WIDTH = REQ_WIDTH,
    parameter int DEPTH = REQ_DEPTH,
    parameter int NREAD = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             init_busy,
    input  logic                             wen0,
    input  logic [$clog2(DEPTH)-1:0]         waddr0,
    input  logic [WIDTH/8-1:0]               wbe0,
    input  logic [WIDTH-1:0]                 wdata0,
    input  logic                             wen1,
    output logic                             wready1,
    input  logic [$clog2(DEPTH)-1:0]         waddr1,
    input  logic [WIDTH/8-1:0]               wbe1,
    input  logic [WIDTH-1:0]                 wdata1,
    input  logic [NREAD*$clog2(DEPTH)-1:0]   raddr,
    output logic [NREAD*WIDTH-1:0]           rdata
);

    localparam int AW    = $clog2(DEPTH);
    localparam int BEW   = WIDTH / 8;
    localparam int NBANK = DEPTH / BANK_DEPTH;
    localparam int BSW   = (NBANK > 1) ? $clog2(NBANK) : 1;

    if (WIDTH % 8 != 0 || WIDTH != REQ_WIDTH) begin : g_bad_width
        $error("lutram_mp_array: WIDTH must be a multiple of 8 and match lutram_mp_pkg::REQ_WIDTH");
    end
    if (DEPTH < BANK_DEPTH || (DEPTH & (DEPTH - 1)) != 0 || DEPTH != REQ_DEPTH) begin : g_bad_depth
        $error("lutram_mp_array: DEPTH must be a power of 2, >= 64, and match lutram_mp_pkg::REQ_DEPTH");
    end
    if (NREAD < 1 || NREAD > 3) begin : g_bad_nread
        $error("lutram_mp_array: NREAD must be 1..3");
    end

    function automatic logic [BSW-1:0] bank_of(input logic [AW-1:0] a);
        return BSW'(a >> BANK_AW);
    endfunction

    logic                  busy_q;
    logic [AW-1:0]         sweep_cnt;
    logic                  hold_valid;
    wr_req_t               hold;
    wr_req_t               req0;
    wr_req_t               req1;
    wr_req_t               phys;
    logic                  phys_we;
    logic [BSW-1:0]        phys_sel;
    logic [BEW-1:0]        hold_be_left;
    logic [BEW-1:0]        bank_wen   [NBANK];
    logic [NREAD*WIDTH-1:0] bank_rdata [NBANK];
    logic [NREAD*BANK_AW-1:0] bank_raddr;
    logic [NREAD*WIDTH-1:0] rd_next;
    logic [NREAD*WIDTH-1:0] rdata_p1;

    assign req0         = '{addr: waddr0, be: wbe0, data: wdata0};
    assign req1         = '{addr: waddr1, be: wbe1, data: wdata1};
    assign init_busy    = busy_q;
    assign wready1      = !hold_valid && !busy_q;
    assign hold_be_left = hold.be & ~wbe0;
    assign phys_sel     = bank_of(phys.addr);
    assign rdata        = rdata_p1;

    // Zero-fill sweep: one entry per cycle, restarts from 0 on every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b1;
            sweep_cnt <= '0;
        end else if (busy_q) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == AW'(DEPTH - 1)) busy_q <= 1'b0;
        end
    end

    // Single physical write port: sweep, then wen0 > hold buffer > wen1.
    always_comb begin
        phys_we = 1'b0;
        phys    = req0;
        if (busy_q) begin
            phys_we = 1'b1;
            phys    = '{addr: sweep_cnt, be: '1, data: '0};
        end else if (wen0) begin
            phys_we = 1'b1;
            phys    = req0;
        end else if (hold_valid) begin
            phys_we = 1'b1;
            phys    = hold;
        end else if (wen1) begin
            phys_we = 1'b1;
            phys    = req1;
        end
    end

    // Hold buffer: parks wen1 when it collides with wen0; wen0 overrides overlapping bytes.
    always_ff @(posedge clk) begin
        if (reset || busy_q) begin
            hold_valid <= 1'b0;
        end else if (wen0) begin
            if (hold_valid) begin
                if (hold.addr == waddr0) begin
                    hold.be <= hold_be_left;
                    if (hold_be_left == '0) hold_valid <= 1'b0;
                end
            end else if (wen1) begin
                hold_valid <= 1'b1;
                hold       <= req1;
            end
        end else if (hold_valid) begin
            hold_valid <= 1'b0;
        end
    end

    always_comb begin
        bank_raddr = '0;
        for (int i = 0; i < NREAD; i++) begin
            bank_raddr[i*BANK_AW +: BANK_AW] = raddr[i*AW +: BANK_AW];
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign bank_wen[b] = (phys_we && phys_sel == BSW'(b)) ? phys.be : '0;

        lutram_bank64 #(
            .WIDTH (WIDTH),
            .NREAD (NREAD)
        ) u_bank (
            .clk   (clk),
            .wen   (bank_wen[b]),
            .waddr (phys.addr[BANK_AW-1:0]),
            .wdata (phys.data),
            .raddr (bank_raddr),
            .rdata (bank_rdata[b])
        );
    end

    // Bank mux, with optional forwarding of pending hold data and then the current write.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_next[i*WIDTH +: WIDTH] = bank_rdata[bank_of(raddr[i*AW +: AW])][i*WIDTH +: WIDTH];
`ifdef LUTRAM_MP_BYPASS_EN
            if (hold_valid && hold.addr == raddr[i*AW +: AW]) begin
                rd_next[i*WIDTH +: WIDTH] = merge_bytes(rd_next[i*WIDTH +: WIDTH], hold.data, hold.be);
            end
            if (phys_we && phys.addr == raddr[i*AW +: AW]) begin
                rd_next[i*WIDTH +: WIDTH] = merge_bytes(rd_next[i*WIDTH +: WIDTH], phys.data, phys.be);
            end
`endif
        end
    end

    // Registered read stage; held at zero while the sweep runs.
    always_ff @(posedge clk) begin
        if (reset || busy_q) begin
            rdata_p1 <= '0;
        end else begin
            rdata_p1 <= rd_next;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(wen1 && !wready1))
                else $error("lutram_mp_array: wen1 while wready1 low, write dropped");
        end
    end
`endif

endmodule

// File: tb/tb_lutram_mp_array.sv
// Self-checking bench for lutram_mp_array (default 64x256, 3 read ports).
// Honours LUTRAM_MP_BYPASS_EN when choosing read-during-write expectations.
module tb_lutram_mp_array;

`ifdef LUTRAM_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         init_busy;
    logic         wen0;
    logic [7:0]   waddr0;
    logic [7:0]   wbe0;
    logic [63:0]  wdata0;
    logic         wen1;
    logic         wready1;
    logic [7:0]   waddr1;
    logic [7:0]   wbe1;
    logic [63:0]  wdata1;
    logic [23:0]  raddr;
    logic [191:0] rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [191:0] exp;
        string        name;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [63:0] model [256];

    lutram_mp_array #(.WIDTH(64), .DEPTH(256), .NREAD(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .wen0      (wen0),
        .waddr0    (waddr0),
        .wbe0      (wbe0),
        .wdata0    (wdata0),
        .wen1      (wen1),
        .wready1   (wready1),
        .waddr1    (waddr1),
        .wbe1      (wbe1),
        .wdata1    (wdata1),
        .raddr     (raddr),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wbe0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wbe1 = '0; wdata1 = '0;
    endtask

    function automatic void mwrite(input int a, input logic [7:0] be, input logic [63:0] d);
        for (int b = 0; b < 8; b++) begin
            if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic [63:0] rdw_exp(input int a, input int wa, input logic [63:0] wd);
        if (BYPASS && a == wa) return wd;
        return model[a];
    endfunction

    task automatic push_read(input int a0, input int a1, input int a2,
                             input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                             input string nm);
        rd_exp_t e;
        raddr  = {8'(a2), 8'(a1), 8'(a0)};
        e.exp  = {e2, e1, e0};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; idle(); raddr = 24'h050505;
        repeat (3) step();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: init_busy=%b expected 1", init_busy); end
        checks++; if (wready1 !== 1'b0) begin errors++; $display("FAIL reset_wready1: wready1=%b expected 0", wready1); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: rdata=%h expected 0", rdata); end
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 1000) begin
            step();
            n++;
            if (n == 10) begin
                checks++; if (wready1 !== 1'b0) begin errors++; $display("FAIL sweep_wready1: wready1=%b expected 0", wready1); end
                checks++; if (rdata !== '0) begin errors++; $display("FAIL sweep_rdata: rdata=%h expected 0", rdata); end
            end
        end
        checks++; if (n != 256) begin errors++; $display("FAIL sweep_length: busy for %0d cycles expected 256", n); end
        checks++; if (wready1 !== 1'b1) begin errors++; $display("FAIL post_sweep_wready1: wready1=%b expected 1", wready1); end
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    task automatic test_zero_fill();
        rd_exp_t ent;
        for (int i = 0; i < 256; i++) begin
            push_read(i, (i + 85) % 256, (i + 170) % 256,
                      model[i], model[(i + 85) % 256], model[(i + 170) % 256], "zero_fill");
            step();
            ent = sb.pop_front(); checks++;
            if (rdata !== ent.exp) begin errors++; $display("FAIL %s[%0d]: rdata=%h expected %h", ent.name, i, rdata, ent.exp); end
        end
    endtask

    task automatic test_wr0_basic();
        rd_exp_t ent;
        wen0 = 1'b1; waddr0 = 8'd5; wbe0 = 8'hFF; wdata0 = 64'h1111_1111_1111_1111;
        step(); mwrite(5, 8'hFF, 64'h1111_1111_1111_1111);
        idle();
        push_read(5, 6, 4, model[5], model[6], model[4], "wr0_basic");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
        checks++; if (rdata[63:0] !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL wr0_const: rdata0=%h expected 1111111111111111", rdata[63:0]); end
    endtask

    task automatic test_wen1_direct();
        rd_exp_t ent;
        wen1 = 1'b1; waddr1 = 8'd30; wbe1 = 8'hFF; wdata1 = 64'h3030_3030_3030_3030;
        step(); mwrite(30, 8'hFF, 64'h3030_3030_3030_3030);
        idle();
        checks++; if (wready1 !== 1'b1) begin errors++; $display("FAIL wen1_direct_ready: wready1=%b expected 1", wready1); end
        push_read(30, 30, 29, model[30], model[30], model[29], "wen1_direct");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
    endtask

    task automatic test_hold();
        rd_exp_t ent;
        wen0 = 1'b1; waddr0 = 8'd7; wbe0 = 8'hFF; wdata0 = 64'h7777_7777_7777_7777;
        wen1 = 1'b1; waddr1 = 8'd9; wbe1 = 8'hFF; wdata1 = 64'h9999_9999_9999_9999;
        step(); mwrite(7, 8'hFF, 64'h7777_7777_7777_7777);
        idle();
        checks++; if (wready1 !== 1'b0) begin errors++; $display("FAIL hold_busy_ready: wready1=%b expected 0", wready1); end
        push_read(9, 7, 9, rdw_exp(9, 9, 64'h9999_9999_9999_9999), model[7],
                  rdw_exp(9, 9, 64'h9999_9999_9999_9999), "hold_drain_read");
        step(); mwrite(9, 8'hFF, 64'h9999_9999_9999_9999);
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
        checks++; if (wready1 !== 1'b1) begin errors++; $display("FAIL hold_empty_ready: wready1=%b expected 1", wready1); end
        push_read(9, 9, 7, model[9], model[9], model[7], "hold_written");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
    endtask

    task automatic test_ordering();
        rd_exp_t ent;
        wen0 = 1'b1; waddr0 = 8'd3; wbe0 = 8'hFF; wdata0 = 64'hDEAD_BEEF_CAFE_F00D;
        step(); mwrite(3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        wen0 = 1'b1; waddr0 = 8'd20; wbe0 = 8'hFF; wdata0 = 64'hC0C0_C0C0_C0C0_C0C0;
        wen1 = 1'b1; waddr1 = 8'd3;  wbe1 = 8'h0F; wdata1 = 64'hA7A6_A5A4_A3A2_A1A0;
        step(); mwrite(20, 8'hFF, 64'hC0C0_C0C0_C0C0_C0C0);
        idle();
        wen0 = 1'b1; waddr0 = 8'd3; wbe0 = 8'h03; wdata0 = 64'hB7B6_B5B4_B3B2_B1B0;
        step(); mwrite(3, 8'h03, 64'hB7B6_B5B4_B3B2_B1B0);
        idle();
        checks++; if (wready1 !== 1'b0) begin errors++; $display("FAIL order_hold_kept: wready1=%b expected 0", wready1); end
        step(); mwrite(3, 8'h0C, 64'hA7A6_A5A4_A3A2_A1A0);
        checks++; if (wready1 !== 1'b1) begin errors++; $display("FAIL order_hold_drained: wready1=%b expected 1", wready1); end
        push_read(3, 20, 3, model[3], model[20], model[3], "ordering");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
        checks++; if (rdata[63:0] !== 64'hDEAD_BEEF_A3A2_B1B0) begin errors++; $display("FAIL order_const: rdata0=%h expected deadbeefa3a2b1b0", rdata[63:0]); end

        wen0 = 1'b1; waddr0 = 8'd50; wbe0 = 8'hFF; wdata0 = 64'h5050_5050_5050_5050;
        wen1 = 1'b1; waddr1 = 8'd40; wbe1 = 8'h0F; wdata1 = 64'hEEEE_EEEE_EEEE_EEEE;
        step(); mwrite(50, 8'hFF, 64'h5050_5050_5050_5050);
        idle();
        wen0 = 1'b1; waddr0 = 8'd40; wbe0 = 8'hFF; wdata0 = 64'hF4F4_F4F4_F4F4_F4F4;
        step(); mwrite(40, 8'hFF, 64'hF4F4_F4F4_F4F4_F4F4);
        idle();
        checks++; if (wready1 !== 1'b1) begin errors++; $display("FAIL order_invalidate: wready1=%b expected 1", wready1); end
        step();
        push_read(40, 50, 40, model[40], model[50], model[40], "order_invalidate_data");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
    endtask

    task automatic test_byte_enables();
        rd_exp_t ent;
        wen0 = 1'b1; waddr0 = 8'd5; wbe0 = 8'h00; wdata0 = '1;
        step();
        idle();
        wen1 = 1'b1; waddr1 = 8'd5; wbe1 = 8'h81; wdata1 = 64'hAB00_0000_0000_00CD;
        step(); mwrite(5, 8'h81, 64'hAB00_0000_0000_00CD);
        idle();
        push_read(5, 5, 5, model[5], model[5], model[5], "byte_enables");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
        checks++; if (rdata[63:0] !== 64'hAB11_1111_1111_11CD) begin errors++; $display("FAIL be_const: rdata0=%h expected ab111111111111cd", rdata[63:0]); end
    endtask

    task automatic test_read_during_write();
        rd_exp_t ent;
        wen0 = 1'b1; waddr0 = 8'd12; wbe0 = 8'hFF; wdata0 = 64'h1212_1212_1212_1212;
        step(); mwrite(12, 8'hFF, 64'h1212_1212_1212_1212);
        wdata0 = 64'h3434_3434_3434_3434;
        push_read(12, 12, 13, rdw_exp(12, 12, wdata0), rdw_exp(12, 12, wdata0), model[13], "rdw_same_cycle");
        step(); mwrite(12, 8'hFF, 64'h3434_3434_3434_3434);
        idle();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
        push_read(12, 13, 12, model[12], model[13], model[12], "rdw_after");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
    endtask

    task automatic test_back_to_back();
        rd_exp_t ent;
        logic [63:0] d;
        for (int k = 0; k < 8; k++) begin
            d = {8{8'(k + 1)}};
            wen0 = 1'b1; waddr0 = 8'(60 + k); wbe0 = 8'hFF; wdata0 = d;
            push_read(59 + k, 60 + k, 63, rdw_exp(59 + k, 60 + k, d), rdw_exp(60 + k, 60 + k, d),
                      rdw_exp(63, 60 + k, d), "back_to_back");
            step(); mwrite(60 + k, 8'hFF, d);
            ent = sb.pop_front(); checks++;
            if (rdata !== ent.exp) begin errors++; $display("FAIL %s[%0d]: rdata=%h expected %h", ent.name, k, rdata, ent.exp); end
        end
        idle();
    endtask

    task automatic test_reset_mid_sweep();
        rd_exp_t ent;
        int n;
        wen0 = 1'b1; waddr0 = 8'd200; wbe0 = 8'hFF; wdata0 = 64'h2222_2222_2222_2222;
        step();
        idle();
        reset = 1'b1; step(); reset = 1'b0;
        repeat (100) step();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: init_busy=%b expected 1", init_busy); end
        reset = 1'b1; step();
        checks++; if (wready1 !== 1'b0) begin errors++; $display("FAIL mid_reset_wready1: wready1=%b expected 0", wready1); end
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++; if (n != 256) begin errors++; $display("FAIL restart_length: busy for %0d cycles expected 256", n); end
        for (int i = 0; i < 256; i++) model[i] = '0;
        push_read(200, 5, 3, model[200], model[5], model[3], "restart_zeroed");
        step();
        ent = sb.pop_front(); checks++;
        if (rdata !== ent.exp) begin errors++; $display("FAIL %s: rdata=%h expected %h", ent.name, rdata, ent.exp); end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_wr0_basic();
        test_wen1_direct();
        test_hold();
        test_ordering();
        test_byte_enables();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
